// File: rtl/pe_pkg.sv
// Shared types for the priority-encoder back end: index-width helper and the
// result word that travels through the index FIFO.
package pe_pkg;

  localparam int PE_WIDTH = 16;

  function automatic int pe_idx_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  localparam int PE_IDX_W = pe_idx_w(PE_WIDTH);

  typedef struct packed {
    logic [PE_IDX_W-1:0] left_idx;
    logic [PE_IDX_W-1:0] right_idx;
    logic [PE_IDX_W-1:0] span;
    logic                zero;
    logic                err;
  } pe_result_t;

endpackage

// File: rtl/onehot_idx_enc.sv
// Lowest-set-bit index of a nominally one-hot word, with a flag raised when
// more than one bit is set. An all-zero word yields index 0.
module onehot_idx_enc
  import pe_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int IDX_W = pe_idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] word_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             multi_hot_o,
  output logic             zero_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Descending scan so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (word_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign multi_hot_o = |(word_i & (word_i - ONE));
  assign zero_o      = ~|word_i;

endmodule

// File: rtl/priority_index_fifo.sv
// Converts the encoder's MSB/LSB one-hot pair into indices, span and error
// flags, then buffers the results in a show-ahead FIFO with valid/ready out.
module priority_index_fifo
  import pe_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = pe_idx_w(WIDTH),
  localparam int IDX_F     = $clog2(FIFO_DEPTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_left_i,
  input  logic [WIDTH-1:0] data_right_i,
  input  logic             data_val_i,
  output logic [IDX_W-1:0] left_idx_o,
  output logic [IDX_W-1:0] right_idx_o,
  output logic [IDX_W-1:0] span_o,
  output logic             zero_o,
  output logic             err_o,
  output logic             data_val_o,
  input  logic             data_ready_i,
  output logic [IDX_F:0]   level_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam logic [IDX_F:0] FULL_CNT = (IDX_F + 1)'(FIFO_DEPTH);

  // The FIFO word layout is fixed by the package; reject mismatched widths.
  if (IDX_W != PE_IDX_W) begin : g_width_check
    $error("priority_index_fifo: WIDTH must give the package index width");
  end

  logic [IDX_W-1:0] w_l_idx;
  logic [IDX_W-1:0] w_r_idx;
  logic             w_l_mh;
  logic             w_r_mh;
  logic             w_l_zero;
  logic             w_r_zero;
  pe_result_t       w_res_p0;

  onehot_idx_enc #(.WIDTH(WIDTH)) u_enc_left (
    .word_i      (data_left_i),
    .idx_o       (w_l_idx),
    .multi_hot_o (w_l_mh),
    .zero_o      (w_l_zero)
  );

  onehot_idx_enc #(.WIDTH(WIDTH)) u_enc_right (
    .word_i      (data_right_i),
    .idx_o       (w_r_idx),
    .multi_hot_o (w_r_mh),
    .zero_o      (w_r_zero)
  );

  always_comb begin
    w_res_p0           = '0;
    w_res_p0.left_idx  = w_l_idx;
    w_res_p0.right_idx = w_r_idx;
    w_res_p0.zero      = w_l_zero & w_r_zero;
    w_res_p0.err       = w_l_mh | w_r_mh | (w_l_zero ^ w_r_zero) | (w_l_idx < w_r_idx);
    if (!w_res_p0.zero && !w_res_p0.err) w_res_p0.span = w_l_idx - w_r_idx;
  end

  // ---- stage 1: registered encode result ----
  pe_result_t r_res_p1;
  logic       r_vld_p1;

  always_ff @(posedge clk_i) begin
    if (srst_i) r_vld_p1 <= 1'b0;
    else        r_vld_p1 <= data_val_i;
  end

  always_ff @(posedge clk_i) begin
    if (data_val_i) r_res_p1 <= w_res_p0;
  end

  // ---- stage 2: show-ahead result FIFO ----
  pe_result_t       r_mem [FIFO_DEPTH];
  logic [IDX_F-1:0] r_wr_ptr;
  logic [IDX_F-1:0] r_rd_ptr;
  logic [IDX_F:0]   r_count;
  logic [CNT_W-1:0] r_drop;
  logic             w_vld_p2;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;
  logic             w_drop;
  pe_result_t       w_head;

  assign w_vld_p2 = (r_count != '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_pop    = w_vld_p2 & data_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr     = r_vld_p1 & (~w_full | w_pop);
  assign w_drop   = r_vld_p1 & w_full & ~w_pop;

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_res_p1;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + IDX_F'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + IDX_F'(1);
      if (w_wr && !w_pop)      r_count <= r_count + (IDX_F + 1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (IDX_F + 1)'(1);
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + CNT_W'(1);
    end
  end

  // Fields are forced to zero while empty so stale storage never shows.
  assign w_head      = w_vld_p2 ? r_mem[r_rd_ptr] : '0;
  assign left_idx_o  = w_head.left_idx;
  assign right_idx_o = w_head.right_idx;
  assign span_o      = w_head.span;
  assign zero_o      = w_head.zero;
  assign err_o       = w_head.err;
  assign data_val_o  = w_vld_p2;
  assign level_o     = r_count;
  assign drop_cnt_o  = r_drop;

endmodule

// File: tb/tb_priority_index_fifo.sv
// Bench for priority_index_fifo: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_priority_index_fifo;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [15:0] dl = '0, dr = '0;
  logic        dv = 1'b0, rdy = 1'b0;
  logic [3:0]  li, ri, sp;
  logic        zo, eo, vo;
  logic [2:0]  lvl;
  logic [15:0] drp;

  logic [15:0] s_dl = 16'h0010, s_dr = 16'h0002;
  logic        s_dv = 1'b0, s_rdy = 1'b0;
  logic [3:0]  s_li, s_ri, s_sp;
  logic        s_zo, s_eo, s_vo;
  logic [2:0]  s_lvl;
  logic [1:0]  s_drp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  priority_index_fifo #(.WIDTH(16), .FIFO_DEPTH(4), .CNT_W(16)) u_dut (
    .clk_i(clk), .srst_i(srst), .data_left_i(dl), .data_right_i(dr),
    .data_val_i(dv), .left_idx_o(li), .right_idx_o(ri), .span_o(sp),
    .zero_o(zo), .err_o(eo), .data_val_o(vo), .data_ready_i(rdy),
    .level_o(lvl), .drop_cnt_o(drp)
  );

  priority_index_fifo #(.WIDTH(16), .FIFO_DEPTH(4), .CNT_W(2)) u_sat (
    .clk_i(clk), .srst_i(srst), .data_left_i(s_dl), .data_right_i(s_dr),
    .data_val_i(s_dv), .left_idx_o(s_li), .right_idx_o(s_ri), .span_o(s_sp),
    .zero_o(s_zo), .err_o(s_eo), .data_val_o(s_vo), .data_ready_i(s_rdy),
    .level_o(s_lvl), .drop_cnt_o(s_drp)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the expected FIFO contents as a queue of results.
  typedef struct {
    int l;
    int r;
    int s;
    int z;
    int e;
  } exp_t;

  function automatic exp_t enc(input logic [15:0] a, input logic [15:0] b);
    exp_t        x;
    logic [15:0] la, lb;
    int          ca, cb;
    la  = a & (~a + 16'd1);
    lb  = b & (~b + 16'd1);
    ca  = $countones(a);
    cb  = $countones(b);
    x.l = (a == 0) ? 0 : $clog2(la);
    x.r = (b == 0) ? 0 : $clog2(lb);
    x.z = (ca == 0 && cb == 0) ? 1 : 0;
    x.e = (ca > 1 || cb > 1 || ((ca == 0) != (cb == 0)) || x.l < x.r) ? 1 : 0;
    x.s = (x.z == 1 || x.e == 1) ? 0 : x.l - x.r;
    return x;
  endfunction

  exp_t q[$];
  exp_t pend;
  bit   pend_v = 0;
  int   drops = 0;
  bit   mdl_live = 0;

  always @(posedge clk) begin
    if (srst) begin
      q.delete();
      pend_v   = 0;
      drops    = 0;
      mdl_live = 1;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (pend_v) begin
        if (q.size() < 4) q.push_back(pend);
        else if (drops != 65535) drops++;
      end
      pend   = enc(dl, dr);
      pend_v = dv;
    end
  end

  always @(negedge clk) begin
    if (mdl_live) begin
      chk("model_val", int'(vo), (q.size() > 0) ? 1 : 0);
      chk("model_level", int'(lvl), q.size());
      chk("model_drop", int'(drp), drops);
      if (q.size() > 0) begin
        chk("model_left", int'(li), q[0].l);
        chk("model_right", int'(ri), q[0].r);
        chk("model_span", int'(sp), q[0].s);
        chk("model_zero", int'(zo), q[0].z);
        chk("model_err", int'(eo), q[0].e);
      end
    end
  end

  task automatic cyc(input bit v, input logic [15:0] l, input logic [15:0] r, input bit rd);
    @(negedge clk);
    dv  = v;
    dl  = l;
    dr  = r;
    rdy = rd;
  endtask

  initial begin
    // Reset state
    repeat (3) cyc(0, 16'h0, 16'h0, 0);
    chk("rst_level", int'(lvl), 0);
    chk("rst_val", int'(vo), 0);
    chk("rst_drop", int'(drp), 0);
    chk("rst_left", int'(li), 0);
    chk("rst_err", int'(eo), 0);
    srst = 1'b0;

    // Single word, two-cycle latency, one cycle of valid
    cyc(1, 16'h0100, 16'h0004, 1);
    cyc(0, 16'h0, 16'h0, 1);
    chk("lat_early_val", int'(vo), 0);
    cyc(0, 16'h0, 16'h0, 1);
    chk("t1_val", int'(vo), 1);
    chk("t1_left", int'(li), 8);
    chk("t1_right", int'(ri), 2);
    chk("t1_span", int'(sp), 6);
    chk("t1_err", int'(eo), 0);
    cyc(0, 16'h0, 16'h0, 1);
    chk("t1_val_drop", int'(vo), 0);

    // Zero pair, then a multi-hot left word
    cyc(1, 16'h0000, 16'h0000, 1);
    cyc(1, 16'h0300, 16'h0001, 1);
    cyc(0, 16'h0, 16'h0, 1);
    chk("t2_zero", int'(zo), 1);
    chk("t2_zero_err", int'(eo), 0);
    chk("t2_zero_idx", int'(li) + int'(ri), 0);
    chk("t2_zero_span", int'(sp), 0);
    cyc(0, 16'h0, 16'h0, 1);
    chk("t2_mh_err", int'(eo), 1);
    chk("t2_mh_span", int'(sp), 0);
    chk("t2_mh_left", int'(li), 8);
    repeat (2) cyc(0, 16'h0, 16'h0, 1);

    // Overflow: six words into four slots with ready low
    for (int i = 1; i <= 6; i++) cyc(1, 16'(1) << (i + 8), 16'(1) << i, 0);
    cyc(0, 16'h0, 16'h0, 0);
    cyc(0, 16'h0, 16'h0, 0);
    chk("t3_level", int'(lvl), 4);
    chk("t3_drop", int'(drp), 2);
    chk("t3_head", int'(li), 9);
    rdy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t3_drain", int'(li), 9 + k);
    end
    @(negedge clk);
    chk("t3_empty", int'(lvl), 0);

    // Full FIFO with simultaneous write and pop every cycle
    for (int i = 0; i < 5; i++) cyc(1, 16'(1) << i, 16'h0001, 0);
    cyc(1, 16'(1) << 5, 16'h0001, 1);
    chk("t4_full", int'(lvl), 4);
    for (int k = 0; k < 8; k++) begin
      cyc(1, 16'(1) << (6 + k), 16'h0001, 1);
      chk("t4_level", int'(lvl), 4);
      chk("t4_drop", int'(drp), 2);
      chk("t4_head", int'(li), k + 1);
    end
    repeat (7) cyc(0, 16'h0, 16'h0, 1);
    chk("t4_empty", int'(lvl), 0);

    // Reset with stored words and one in flight
    for (int i = 0; i < 4; i++) cyc(1, 16'(1) << (i + 4), 16'(1) << i, 0);
    cyc(0, 16'h0, 16'h0, 0);
    chk("t5_pre_level", int'(lvl), 3);
    srst = 1'b1;
    cyc(0, 16'h0, 16'h0, 1);
    srst = 1'b0;
    chk("t5_level", int'(lvl), 0);
    chk("t5_val", int'(vo), 0);
    chk("t5_drop", int'(drp), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 16'h0, 16'h0, 1);
      chk("t5_quiet", int'(vo), 0);
    end

    // Drop counter saturation on the 2-bit instance
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 7) chk("t6_drop2", int'(s_drp), 2);
      if (i == 8) chk("t6_drop3", int'(s_drp), 3);
      s_dv = 1'b1;
    end
    @(negedge clk);
    s_dv = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_sat", int'(s_drp), 3);
    chk("t6_level", int'(s_lvl), 4);
    chk("t6_head", int'(s_li), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
